pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Fetch sequencer for the instruction-fetch stage. It owns the fetch address and drives the PC register's load and next-value inputs. It handshakes with instruction memory and buffers one fetched word while the pipeline is stalled. It also applies exception, jump and branch redirects with fixed priority, including cancellation of an in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- EXC_VECTOR, 32'h8000_0180, exception redirect target

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset; asynchronous, active-high (1 = in reset)
- stall  in  1  hazard hold from ID; fetched word must not be delivered
- exc  in  1  exception redirect request
- jump  in  1  jump redirect request
- jump_target  in  32  jump target address
- branch_taken  in  1  branch redirect request
- branch_target  in  32  branch target address
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- pc  out  32  current fetch PC
- pc_next  out  32  value PC register captures at next edge
- pc_load  out  1  PC register write enable, paired with pc_next
- fetch_valid  out  1  instr valid, one-cycle pulse
- instr  out  32  delivered instruction word
- redirect  out  1  one-cycle flush pulse to IF/ID
- align_fault  out  1  misaligned-target pulse; tied 0 without the Configuration macro

## Operation
- States: BOOT, FETCH, HOLD, DRAIN.
- Reset (async) forces the following values; state = BOOT:
  - pc = imem_addr = pc_next = RESET_PC
  - instr = 0
  - imem_req = pc_load = fetch_valid = redirect = align_fault = 0
- imem_req = 1 in FETCH and DRAIN only. imem_addr is stable while imem_req = 1 and ack is not yet seen.
- Redirect selection is combinational, priority exc > jump > branch_taken.
  - Targets are EXC_VECTOR, jump_target and branch_target respectively.
  - A redirect overrides stall in every state.
- BOOT: next cycle → FETCH. If a redirect is present, pc ← target first.
- FETCH, ack, no stall, no redirect:
  - pc ← pc+4, modulo 2^32 (0xFFFF_FFFC → 0x0).
  - instr ← imem_rdata, fetch_valid pulses.
  - Stay in FETCH.
- FETCH, ack, stall, no redirect: buffer ← imem_rdata, → HOLD. pc is unchanged.
- FETCH, no ack, redirect:
  - pc ← target; imem_addr holds the old address.
  - redirect pulses, → DRAIN.
- FETCH, ack, redirect: word discarded, pc ← target, redirect pulses, stay in FETCH.
- HOLD, stall released, no redirect:
  - instr ← buffer, fetch_valid pulses.
  - pc ← pc+4, → FETCH.
- HOLD, redirect: buffer discarded, pc ← target, redirect pulses, → FETCH.
- DRAIN:
  - Hold the old request until ack, then discard the word and → FETCH at pc.
  - A further redirect in DRAIN overwrites pc and pulses redirect again.
- pc_load = 1 exactly in cycles where pc changes at the next edge; pc_next equals that new value. Otherwise pc_next = pc.
- imem_addr updates to pc on entry to FETCH.

## Timing
- pc_next, pc_load, imem_req: combinational from state and inputs.
- pc, imem_addr, instr, fetch_valid, redirect, align_fault: registered.
- First request is in the cycle after rstn deasserts plus one BOOT cycle.
- Zero-wait memory (ack every cycle) sustains one fetch per cycle. fetch_valid appears one cycle after the accepting ack.
- A redirect is visible on imem_addr within 1 cycle from FETCH or HOLD. From DRAIN it is visible 1 cycle after the pending ack.
- Asserting rstn in any state, including mid-DRAIN, forces reset values immediately. No outstanding request is honoured.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Any redirect target with bits [1:0] ≠ 0 is not taken.
  - pc ← EXC_VECTOR instead, and align_fault pulses for 1 cycle alongside redirect.
- Undefined: target bits [1:0] are forced to 00, and align_fault is constant 0.

## Test plan
- **Reset and streaming:** RESET_PC = 0, imem_ack = 1 constantly → imem_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles. fetch_valid is high from the second request onward, and instr follows imem_rdata with one cycle of latency.
- **Wait states:** ack withheld 3 cycles at address 0x4 → imem_req/imem_addr held at 0x4 and pc_load = 0 for 3 cycles, then advance to 0x8.
- **Stall on ack:** ack at 0x10 with rdata 0xDEADBEEF and stall for 2 cycles → HOLD, fetch_valid = 0. On release, fetch_valid = 1 with instr = 0xDEADBEEF, and the next request is at 0x14.
- **Redirect with request pending:** jump 0x200 and branch 0x100 together while 0x20 is unacknowledged → redirect pulse. 0x20 is held until ack, that word is dropped (no fetch_valid), and the next request is at 0x200.
- **Wrap and reset mid-DRAIN:** RESET_PC = 0xFFFF_FFFC → second request at 0x0. Asserting rstn during DRAIN returns all outputs to reset values in the same cycle.
- **Alignment:** jump_target = 0x102. With PC_ALIGN_CHECK_EN → next request at 0x8000_0180 and align_fault pulses once. Without it → next request at 0x100.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, handshakes imem, parks one word across a stall, applies exc > jump > branch redirects.
// fetch_valid follows the accepting ack by 1 cycle; no request in HOLD; PC_ALIGN_CHECK_EN enables misaligned-target trapping.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        exc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic        fetch_valid,
  output logic [31:0] instr,
  output logic        redirect,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] buf_q;
  logic        fv_q;
  logic        redir_q;

  logic        rd_any;
  logic [31:0] rd_raw;
  logic [31:0] rd_tgt;
  logic [31:0] pc_inc;
  logic [31:0] pc_cand;
  logic [31:0] instr_d;
  logic        addr_ld;
  logic        buf_ld;
  logic        instr_ld;

  assign rd_any = exc | jump | branch_taken;
  assign rd_raw = exc ? EXC_VECTOR : (jump ? jump_target : branch_target);
  assign pc_inc = pc_q + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  logic rd_misal;
  logic af_q;

  // A misaligned target is never followed; it traps to the exception vector instead.
  assign rd_misal = rd_any && (rd_raw[1:0] != 2'b00);
  assign rd_tgt   = rd_misal ? EXC_VECTOR : rd_raw;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      af_q <= 1'b0;
    end else begin
      af_q <= rd_misal;
    end
  end

  assign align_fault = af_q;
`else
  assign rd_tgt      = rd_raw & ~32'h0000_0003;
  assign align_fault = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_cand  = pc_q;
    addr_ld  = 1'b0;
    buf_ld   = 1'b0;
    instr_ld = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        addr_ld = 1'b1;
        if (rd_any) pc_cand = rd_tgt;
      end
      FETCH: begin
        if (rd_any) begin
          pc_cand = rd_tgt;
          // Unacked request must still complete; its word is dropped in DRAIN.
          if (imem_ack) addr_ld = 1'b1;
          else          state_d = DRAIN;
        end else if (imem_ack) begin
          if (stall) begin
            buf_ld  = 1'b1;
            state_d = HOLD;
          end else begin
            instr_ld = 1'b1;
            pc_cand  = pc_inc;
            addr_ld  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (rd_any) begin
          pc_cand = rd_tgt;
          state_d = FETCH;
          addr_ld = 1'b1;
        end else if (!stall) begin
          instr_ld = 1'b1;
          pc_cand  = pc_inc;
          state_d  = FETCH;
          addr_ld  = 1'b1;
        end
      end
      DRAIN: begin
        if (rd_any) pc_cand = rd_tgt;
        if (imem_ack) begin
          state_d = FETCH;
          addr_ld = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign instr_d = (state_q == HOLD) ? buf_q : imem_rdata;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= 32'h0;
      buf_q   <= 32'h0;
      fv_q    <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_cand;
      if (addr_ld)  addr_q  <= pc_cand;
      if (instr_ld) instr_q <= instr_d;
      if (buf_ld)   buf_q   <= imem_rdata;
      fv_q    <= instr_ld;
      redir_q <= rd_any;
    end
  end

  // Combinational PC-register controls are forced quiet while reset is held.
  assign pc_next     = rstn ? RESET_PC : pc_cand;
  assign pc_load     = !rstn && (pc_cand != pc_q);
  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign fetch_valid = fv_q;
  assign redirect    = redir_q;

endmodule
